// File: rtl/cursor_plot_ctrl_pkg.sv
// cursor_plot_ctrl_pkg: shared state encoding, screen geometry, colours and canvas address packing
package cursor_plot_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, ERASE, PAINT, DRAW} state_t;
  localparam logic [8:0] SCREEN_W = 9'd160;
  localparam logic [7:0] SCREEN_H = 8'd120;
  localparam int CUR_SIZE = 4;
  localparam logic [2:0] CUR_COLOUR = 3'b101;
  localparam logic [2:0] BG_COLOUR = 3'b000;
  function automatic logic [14:0] pack_addr(input logic [7:0] x, input logic [6:0] y);
    return {y, x};
  endfunction
endpackage

// File: rtl/cursor_plot_ctrl_if.sv
// cursor_plot_ctrl_if: requester, canvas RAM and VGA plot signals of the cursor plot controller
interface cursor_plot_ctrl_if;
  logic [7:0] cur_x;
  logic [6:0] cur_y;
  logic clear_req;
  logic paint_req;
  logic [2:0] paint_colour;
  logic [2:0] canvas_rdata;
  logic [14:0] canvas_addr;
  logic canvas_we;
  logic [2:0] canvas_wdata;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic vga_plot;
  logic clear_ack;
  logic paint_ack;
  logic busy;
  modport master (
    output cur_x, cur_y, clear_req, paint_req, paint_colour, canvas_rdata,
    input canvas_addr, canvas_we, canvas_wdata, vga_x, vga_y, vga_colour, vga_plot, clear_ack, paint_ack, busy
  );
  modport slave (
    input cur_x, cur_y, clear_req, paint_req, paint_colour, canvas_rdata,
    output canvas_addr, canvas_we, canvas_wdata, vga_x, vga_y, vga_colour, vga_plot, clear_ack, paint_ack, busy
  );
endinterface

// File: rtl/cursor_plot_ctrl_block_scan.sv
// block_scan: 4x4 row-major offset walker emitting block pixel coordinates, bounds flag and a one-step lookahead address
module block_scan
  import cursor_plot_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] base_x,
  input  logic [6:0] base_y,
  output logic [7:0] px,
  output logic [6:0] py,
  output logic       in_bounds,
  output logic [7:0] nx,
  output logic [6:0] ny,
  output logic       first,
  output logic       last,
  output logic       done
);
  localparam logic [3:0] LAST = 4'(CUR_SIZE * CUR_SIZE - 1);
  logic [3:0] cnt, ncnt;
  logic [7:0] bx;
  logic [6:0] by;
  logic [8:0] wx;
  logic [7:0] wy;
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      bx <= '0;
      by <= '0;
      done <= 1'b0;
    end else begin
      cnt <= ncnt;
      done <= last && !start;
      if (start) begin
        bx <= base_x;
        by <= base_y;
      end
    end
  // nx/ny give the pixel that will be current next cycle, so a read can be issued a cycle early
  always_comb begin
    ncnt = start ? 4'd0 : cnt + 4'd1;
    wx = {1'b0, bx} + {7'b0, cnt[1:0]};
    wy = {1'b0, by} + {6'b0, cnt[3:2]};
    px = wx[7:0];
    py = wy[6:0];
    in_bounds = wx < SCREEN_W && wy < SCREEN_H;
    nx = (start ? base_x : bx) + {6'b0, ncnt[1:0]};
    ny = (start ? base_y : by) + {5'b0, ncnt[3:2]};
    first = cnt == 4'd0;
    last = cnt == LAST;
  end
endmodule

// File: rtl/cursor_plot_ctrl.sv
// cursor_plot_ctrl: arbitrates clear/paint/move and sequences framebuffer and canvas pixel writes
module cursor_plot_ctrl
  import cursor_plot_ctrl_pkg::*;
(
  input logic         CLOCK_50,
  input logic         reset,
  cursor_plot_ctrl_if.slave bus
);
  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 9'd1);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 8'd1);
  state_t st, st_n;
  logic [7:0] cx, drawn_x, dly_x, px, nx, vx_d;
  logic [6:0] cy, drawn_y, dly_y, py, ny, vy_d;
  logic [2:0] pcol, vc_d, wdata_d;
  logic [14:0] addr_d;
  logic dly_in, inb, first, last, done, start, clear_last, plot_d, we_d;
  block_scan u_scan (
    .clk(CLOCK_50),
    .rst(reset),
    .start(start),
    .base_x(st_n == ERASE ? drawn_x : bus.cur_x),
    .base_y(st_n == ERASE ? drawn_y : bus.cur_y),
    .px(px),
    .py(py),
    .in_bounds(inb),
    .nx(nx),
    .ny(ny),
    .first(first),
    .last(last),
    .done(done)
  );
  always_comb begin
    clear_last = cx == X_LAST && cy == Y_LAST;
    st_n = st;
    case (st)
      IDLE:    st_n = bus.clear_req ? CLEAR : bus.paint_req ? PAINT :
                      (bus.cur_x != drawn_x || bus.cur_y != drawn_y) ? ERASE : IDLE;
      CLEAR:   st_n = clear_last ? DRAW : CLEAR;
      PAINT:   st_n = last ? DRAW : PAINT;
      ERASE:   st_n = done ? DRAW : ERASE;
      DRAW:    st_n = last ? IDLE : DRAW;
      default: st_n = IDLE;
    endcase
    start = st_n != st && st_n inside {ERASE, PAINT, DRAW};
  end
  // ERASE plots lag the canvas read by one cycle, hence the delayed coordinates and the 17th cycle
  always_comb begin
    plot_d = 1'b0;
    we_d = 1'b0;
    vx_d = px;
    vy_d = py;
    vc_d = CUR_COLOUR;
    wdata_d = pcol;
    addr_d = pack_addr(px, py);
    case (st)
      CLEAR: begin
        plot_d = 1'b1;
        we_d = 1'b1;
        vx_d = cx;
        vy_d = cy;
        vc_d = BG_COLOUR;
        wdata_d = BG_COLOUR;
        addr_d = pack_addr(cx, cy);
      end
      PAINT: begin
        plot_d = inb;
        we_d = inb;
        vc_d = pcol;
      end
      ERASE: begin
        plot_d = dly_in && (!first || done);
        vx_d = dly_x;
        vy_d = dly_y;
        vc_d = bus.canvas_rdata;
      end
      DRAW: plot_d = inb;
      default: plot_d = 1'b0;
    endcase
    if (st_n == ERASE) addr_d = pack_addr(nx, ny);
  end
  always_ff @(posedge CLOCK_50)
    if (reset) begin
      st <= CLEAR;
      cx <= '0;
      cy <= '0;
      drawn_x <= '0;
      drawn_y <= '0;
      pcol <= '0;
      dly_x <= '0;
      dly_y <= '0;
      dly_in <= 1'b0;
      bus.canvas_addr <= '0;
      bus.canvas_we <= 1'b0;
      bus.canvas_wdata <= '0;
      bus.vga_x <= '0;
      bus.vga_y <= '0;
      bus.vga_colour <= '0;
      bus.vga_plot <= 1'b0;
      bus.clear_ack <= 1'b0;
      bus.paint_ack <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      st <= st_n;
      cx <= (st == CLEAR && cx != X_LAST) ? cx + 8'd1 : 8'd0;
      cy <= st != CLEAR ? 7'd0 : cx == X_LAST ? (cy == Y_LAST ? 7'd0 : cy + 7'd1) : cy;
      if (start && st_n == DRAW) begin
        drawn_x <= bus.cur_x;
        drawn_y <= bus.cur_y;
      end
      if (start && st_n == PAINT) pcol <= bus.paint_colour;
      dly_x <= px;
      dly_y <= py;
      dly_in <= inb;
      bus.canvas_addr <= addr_d;
      bus.canvas_we <= we_d;
      bus.canvas_wdata <= wdata_d;
      bus.vga_x <= vx_d;
      bus.vga_y <= vy_d;
      bus.vga_colour <= vc_d;
      bus.vga_plot <= plot_d;
      bus.clear_ack <= st == CLEAR && clear_last;
      bus.paint_ack <= st == PAINT && last;
      bus.busy <= st_n != IDLE;
    end
endmodule

// File: doc/cursor_plot_ctrl.md
Name: cursor_plot_ctrl

Overview:
Sequences all pixel writes to the 160x120 3-bit VGA framebuffer and to the external canvas RAM on behalf of the cursor subsystem. It arbitrates three requesters: screen clear, paint stamp at the cursor, and cursor move. For a cursor move it restores the 4x4 block under the old cursor position from the canvas, then draws the new cursor block. It sits between the cursor position counters and the VGA adapter plot port.

Parameters:
SCREEN_W, 160, visible width in pixels
SCREEN_H, 120, visible height in pixels
CUR_SIZE, 4, cursor block edge length in pixels
CUR_COLOUR, 3'b101, cursor colour
BG_COLOUR, 3'b000, clear colour

Ports:
CLOCK_50  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
cur_x  in  8  requested cursor X (top-left corner)
cur_y  in  7  requested cursor Y (top-left corner)
clear_req  in  1  level request to clear the screen; held until clear_ack
paint_req  in  1  level request to stamp a 4x4 block at the cursor; held until paint_ack
paint_colour  in  3  stamp colour, sampled when PAINT is entered
canvas_rdata  in  3  canvas read data, valid 1 cycle after canvas_addr
canvas_addr  out  15  canvas address {y[6:0],x[7:0]}
canvas_we  out  1  canvas write enable
canvas_wdata  out  3  canvas write data
vga_x  out  8  plot X
vga_y  out  7  plot Y
vga_colour  out  3  plot colour
vga_plot  out  1  plot strobe; one pixel per asserted cycle
clear_ack  out  1  one-cycle pulse when CLEAR completes
paint_ack  out  1  one-cycle pulse when PAINT completes
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0; drawn position register = (0,0); next state CLEAR. Reset asserted in any state aborts the operation with no ack, and CLEAR restarts after release.
- States: IDLE, CLEAR, ERASE, PAINT, DRAW.
- IDLE arbitration, evaluated every cycle, fixed priority:
  - clear_req → CLEAR.
  - paint_req → PAINT.
  - (cur_x,cur_y) differs from the drawn position → ERASE, using the old drawn position.
  - Otherwise stay in IDLE.
- Requests are sampled only in IDLE. Position changes during an operation are handled at the next IDLE.
- CLEAR:
  - Raster sweep x 0..159 within y 0..119, one pixel per cycle, 19200 cycles.
  - Each cycle: vga_plot=1 and canvas_we=1, both with BG_COLOUR.
  - On the last pixel: clear_ack pulses; next state DRAW.
- PAINT:
  - Latch paint_colour and the current cursor position at entry.
  - 16 cycles, row-major, offset (dx,dy) 0..3.
  - Each cycle writes canvas and VGA with paint_colour.
  - On the last pixel: paint_ack pulses; next state DRAW.
- ERASE:
  - Cycle i (0..15) drives canvas_addr for offset i, with canvas_we=0.
  - Cycle i+1 plots that pixel with vga_colour=canvas_rdata. vga_x/vga_y are delayed one cycle to match.
  - Total 17 cycles; then DRAW.
- DRAW:
  - Latch cur_x/cur_y into the drawn position at entry.
  - 16 cycles plotting CUR_COLOUR, VGA only; the canvas is not written.
  - Then IDLE.
- Clipping: any pixel with x≥SCREEN_W or y≥SCREEN_H is suppressed. It gets no vga_plot and no canvas_we, but still consumes its cycle. Offset arithmetic uses 9-bit x and 8-bit y so the comparison never wraps.
- All outputs are registered. vga_plot and canvas_we are never high outside an active plot cycle.
- Latency: paint_req seen in IDLE → first plot 1 cycle after PAINT entry. Move → IDLE-to-IDLE takes 17+16 cycles, plus 1 arbitration cycle.

Decomposition:
- Shared package holds:
  - state encoding typedef;
  - SCREEN_W/SCREEN_H/CUR_SIZE;
  - colour constants;
  - canvas address packing function {y,x}.
- One sub-module, block_scan: a 4x4 offset counter with start/last/done that emits (x+dx, y+dy) and an in-bounds flag. It is reused by ERASE, PAINT and DRAW. The CLEAR raster counter stays inline.

Test Plan:
1. Reset release with cur=(10,20) → 19200 plots of colour 000, clear_ack pulse, then 16 plots of 101 at x10..13 / y20..23; busy low afterwards.
2. Canvas preloaded with 011 at (10..13,20..23); cur changes to (11,20) → 16 plots of 011 at the old block, then 16 plots of 101 at (11..14,20..23); total 33 busy cycles plus arbitration.
3. paint_req with paint_colour=110 at cur=(50,60) → 16 canvas writes of 110 and 16 VGA plots of 110, paint_ack for 1 cycle, then a cursor redraw of 101.
4. cur=(154,118) → DRAW emits only the 8 in-bounds plots (y 118..119); no plot at y≥120.
5. clear_req and paint_req asserted in the same cycle → CLEAR first with clear_ack; PAINT follows only after the DRAW completes.
6. reset pulsed mid-ERASE → outputs 0 next cycle; no ack; CLEAR restarts from (0,0).
